mu0_sequencer: RTL and testbench

//  Parametrised successor to the MU0 decoder: owns the instruction register, the FETCH/EXEC1/EXEC2/HALT

---
 rtl/mu0_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mu0_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: instruction register, FETCH/EXEC1/EXEC2/HALT state machine, skip flag,
// saturating retired-instruction counter and decode of every datapath control line.
module mu0_sequencer #(
   parameter int IR_WIDTH  = 16,
   parameter int CNT_WIDTH = 16,
   parameter bit SKIP_EN   = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [IR_WIDTH-1:0]  mem_rdata_i,
   input  logic                 mem_ready_i,
   input  logic                 eq_i,
   input  logic                 mi_i,
   input  logic                 run_i,
   output logic [IR_WIDTH-1:0]  ir_o,
   output logic                 fetch_o,
   output logic                 exec1_o,
   output logic                 exec2_o,
   output logic                 halted_o,
   output logic                 mux1_o,
   output logic                 mux3_o,
   output logic                 mux3_use_all_bits_o,
   output logic                 extra_o,
   output logic                 wren_o,
   output logic                 pc_sload_o,
   output logic                 pc_cnt_en_o,
   output logic                 acc_en_o,
   output logic                 acc_load_o,
   output logic                 acc_shiftin_o,
   output logic                 addsub_o,
   output logic                 skip_o,
   output logic [CNT_WIDTH-1:0] retired_o
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC1 = 2'd1,
      ST_EXEC2 = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JMI = 4'h5;
   localparam logic [3:0] OP_JEQ = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;
   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_SKZ = 4'h9;
   localparam logic [3:0] OP_LSR = 4'hA;
   localparam logic [3:0] OP_ASR = 4'hB;

   state_e                state_q, state_d;
   logic [IR_WIDTH-1:0]   ir_q, ir_d;
   logic                  skip_q, skip_d;
   logic [CNT_WIDTH-1:0]  retired_q, retired_d;
   logic [3:0]            opcode_s;
   logic                  retire_s;
   logic                  take_s;

   assign opcode_s = ir_q[IR_WIDTH-1 -: 4];

   // Next-state and control decode; controls depend on memory handshake in the same cycle.
   always_comb begin
      state_d             = state_q;
      ir_d                = ir_q;
      take_s              = 1'b0;
      mux1_o              = 1'b0;
      mux3_o              = 1'b0;
      mux3_use_all_bits_o = 1'b0;
      extra_o             = 1'b0;
      wren_o              = 1'b0;
      pc_sload_o          = 1'b0;
      pc_cnt_en_o         = 1'b0;
      acc_en_o            = 1'b0;
      acc_load_o          = 1'b0;
      acc_shiftin_o       = 1'b0;
      addsub_o            = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready_i) begin
               ir_d    = mem_rdata_i;
               state_d = ST_EXEC1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC1: begin
            state_d = ST_FETCH;
            case (opcode_s)
               OP_LDA, OP_ADD, OP_SUB: begin
                  // A skipped memory operand op never touches memory: retire straight away.
                  if (skip_q) begin
                     pc_cnt_en_o = 1'b1;
                  end else begin
                     mux1_o  = 1'b1;
                     extra_o = 1'b1;
                     state_d = ST_EXEC2;
                  end
               end
               OP_STA: begin
                  mux1_o      = 1'b1;
                  wren_o      = ~skip_q;
                  pc_cnt_en_o = mem_ready_i;
                  if (mem_ready_i) begin
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_EXEC1;
                  end
               end
               OP_JMP, OP_JMI, OP_JEQ: begin
                  take_s      = ~skip_q & ((opcode_s == OP_JMP) |
                                           ((opcode_s == OP_JMI) & mi_i) |
                                           ((opcode_s == OP_JEQ) & eq_i));
                  pc_sload_o  = take_s;
                  pc_cnt_en_o = ~take_s;
               end
               OP_STP: begin
                  if (skip_q) begin
                     pc_cnt_en_o = 1'b1;
                  end else begin
                     state_d = ST_HALT;
                  end
               end
               OP_LDI: begin
                  acc_en_o    = ~skip_q;
                  acc_load_o  = ~skip_q;
                  mux3_o      = ~skip_q;
                  pc_cnt_en_o = 1'b1;
               end
               OP_LSR, OP_ASR: begin
                  acc_en_o            = ~skip_q;
                  mux3_use_all_bits_o = 1'b1;
                  acc_shiftin_o       = (opcode_s == OP_ASR) & mi_i;
                  pc_cnt_en_o         = 1'b1;
               end
               default: begin
                  pc_cnt_en_o = 1'b1;
               end
            endcase
         end
         ST_EXEC2: begin
            mux1_o              = 1'b1;
            addsub_o            = (opcode_s == OP_ADD);
            mux3_o              = (opcode_s == OP_LDA);
            mux3_use_all_bits_o = (opcode_s == OP_LDA);
            if (mem_ready_i) begin
               acc_en_o    = 1'b1;
               acc_load_o  = 1'b1;
               pc_cnt_en_o = 1'b1;
               state_d     = ST_FETCH;
            end else begin
               state_d = ST_EXEC2;
            end
         end
         ST_HALT: begin
            if (run_i) begin
               pc_cnt_en_o = 1'b1;
               state_d     = ST_FETCH;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // An instruction completes whenever an execute state hands back to FETCH or enters HALT.
   always_comb begin
      retire_s = ((state_q == ST_EXEC1) || (state_q == ST_EXEC2)) &&
                 ((state_d == ST_FETCH) || (state_d == ST_HALT));
      if (retire_s) begin
         skip_d = (SKIP_EN == 1'b1) && (opcode_s == OP_SKZ) && !skip_q && eq_i;
      end else begin
         skip_d = skip_q;
      end
      if (retire_s && (retired_q != {CNT_WIDTH{1'b1}})) begin
         retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         retired_d = retired_q;
      end
   end

   // Sequencer state, instruction register, skip flag and retired counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_FETCH;
         ir_q      <= {IR_WIDTH{1'b0}};
         skip_q    <= 1'b0;
         retired_q <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         skip_q    <= skip_d;
         retired_q <= retired_d;
      end
   end

   assign ir_o      = ir_q;
   assign fetch_o   = (state_q == ST_FETCH);
   assign exec1_o   = (state_q == ST_EXEC1);
   assign exec2_o   = (state_q == ST_EXEC2);
   assign halted_o  = (state_q == ST_HALT);
   assign skip_o    = skip_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed bench for mu0_sequencer: hand-computed expectations for handshake, skip, halt,
// counter saturation (second instance with a 2-bit counter) and reset mid-access.
module tb_mu0_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [15:0] mem_rdata;
   logic        mem_ready, eq, mi, run;
   logic [15:0] ir_o;
   logic        fetch_o, exec1_o, exec2_o, halted_o;
   logic        mux1_o, mux3_o, mux3_all_o, extra_o, wren_o, pc_sload_o, pc_cnt_en_o;
   logic        acc_en_o, acc_load_o, acc_shiftin_o, addsub_o, skip_o;
   logic [15:0] retired_o;
   logic [15:0] ir2_o;
   logic        f2, e12, e22, h2, m12, m32, ma2, ex2, w2, sl2, pc2, ae2, al2, as2, ad2, sk2;
   logic [1:0]  retired2_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_pc_cnt = 0;
   int n_sload  = 0;
   int n_acc_en = 0;
   int n_wren   = 0;
   int snap_pc, snap_acc, snap_wren;
   int exp_ret  = 0;

   always #5 clk_i = ~clk_i;

   mu0_sequencer #(.IR_WIDTH(16), .CNT_WIDTH(16), .SKIP_EN(1'b1)) u_dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .eq_i(eq), .mi_i(mi), .run_i(run), .ir_o(ir_o),
      .fetch_o(fetch_o), .exec1_o(exec1_o), .exec2_o(exec2_o), .halted_o(halted_o),
      .mux1_o(mux1_o), .mux3_o(mux3_o), .mux3_use_all_bits_o(mux3_all_o), .extra_o(extra_o),
      .wren_o(wren_o), .pc_sload_o(pc_sload_o), .pc_cnt_en_o(pc_cnt_en_o),
      .acc_en_o(acc_en_o), .acc_load_o(acc_load_o), .acc_shiftin_o(acc_shiftin_o),
      .addsub_o(addsub_o), .skip_o(skip_o), .retired_o(retired_o)
   );

   mu0_sequencer #(.IR_WIDTH(16), .CNT_WIDTH(2), .SKIP_EN(1'b1)) u_dut2 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .eq_i(eq), .mi_i(mi), .run_i(run), .ir_o(ir2_o),
      .fetch_o(f2), .exec1_o(e12), .exec2_o(e22), .halted_o(h2),
      .mux1_o(m12), .mux3_o(m32), .mux3_use_all_bits_o(ma2), .extra_o(ex2),
      .wren_o(w2), .pc_sload_o(sl2), .pc_cnt_en_o(pc2),
      .acc_en_o(ae2), .acc_load_o(al2), .acc_shiftin_o(as2),
      .addsub_o(ad2), .skip_o(sk2), .retired_o(retired2_o)
   );

   // Pulse counters sampled mid-cycle, when controls have settled.
   always @(negedge clk_i) begin
      if (pc_cnt_en_o) n_pc_cnt <= n_pc_cnt + 1;
      if (pc_sload_o)  n_sload  <= n_sload + 1;
      if (acc_en_o)    n_acc_en <= n_acc_en + 1;
      if (wren_o)      n_wren   <= n_wren + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present an instruction in FETCH and move into EXEC1 (ends 2 time units after the edge).
   task automatic fetch_instr(input logic [15:0] instr);
      mem_ready = 1'b1;
      mem_rdata = instr;
      #1;
      chk("fetch_state", {fetch_o, mux1_o}, 2'b10);
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
      #1;
      chk("exec1_ir", {exec1_o, ir_o}, {1'b1, instr});
   endtask

   initial begin
      rst_n_i = 1'b0; mem_rdata = 16'h0000; mem_ready = 1'b0; eq = 1'b0; mi = 1'b0; run = 1'b0;
      repeat (2) tick();
      chk("rst_state", {fetch_o, exec1_o, exec2_o, halted_o, skip_o}, 5'b10000);
      chk("rst_ir", ir_o, 16'h0000);
      chk("rst_ret", retired_o, 16'd0);
      chk("rst_ctl", {mux1_o, wren_o, pc_cnt_en_o, pc_sload_o, acc_en_o}, 5'b00000);
      rst_n_i = 1'b1;
      tick();

      // LDA with three wait states in EXEC2
      snap_pc = n_pc_cnt; snap_acc = n_acc_en;
      fetch_instr(16'h0005);
      chk("lda_e1", {mux1_o, extra_o, pc_cnt_en_o}, 3'b110);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lda_wait", {exec2_o, mux1_o, mux3_o, mux3_all_o, acc_en_o, pc_cnt_en_o}, 6'b111100);
         tick();
      end
      mem_ready = 1'b1; #1;
      chk("lda_ready", {acc_en_o, acc_load_o, pc_cnt_en_o, addsub_o, mux3_o}, 5'b11101);
      tick(); mem_ready = 1'b0; exp_ret = 1;
      chk("lda_done", {fetch_o, retired_o}, {1'b1, 16'd1});
      chk("lda_pulses", {n_acc_en - snap_acc, n_pc_cnt - snap_pc}, {32'd1, 32'd1});
      chk("sat_1", retired2_o, 2'd1);

      // EQ=1: SKZ then STA is skipped, no write, PC advances by 2
      snap_pc = n_pc_cnt; snap_wren = n_wren;
      eq = 1'b1;
      fetch_instr(16'h9000);
      chk("skz_e1", pc_cnt_en_o, 1'b1);
      tick(); eq = 1'b0; exp_ret++;
      chk("skz_set", skip_o, 1'b1);
      fetch_instr(16'h1010);
      chk("sta_skip_wait", {mux1_o, wren_o, pc_cnt_en_o}, 3'b100);
      tick();
      mem_ready = 1'b1; #1;
      chk("sta_skip_rdy", {wren_o, pc_cnt_en_o}, 2'b01);
      tick(); mem_ready = 1'b0; exp_ret++;
      chk("sta_skip_done", {fetch_o, skip_o, retired_o}, {2'b10, exp_ret[15:0]});
      chk("skz_sta_pc", {n_pc_cnt - snap_pc, n_wren - snap_wren}, {32'd2, 32'd0});
      chk("sat_3", retired2_o, 2'd3);

      // EQ=0: SKZ leaves skip clear, LDA runs through EXEC2
      fetch_instr(16'h9000);
      tick(); exp_ret++;
      chk("skz_noset", skip_o, 1'b0);
      fetch_instr(16'h0011);
      tick();
      chk("lda_e2", exec2_o, 1'b1);
      mem_ready = 1'b1; #1;
      chk("lda2_acc", acc_en_o, 1'b1);
      tick(); mem_ready = 1'b0; exp_ret++;
      chk("lda2_ret", retired_o, exp_ret);
      chk("sat_hold", retired2_o, 2'd3);

      // Skipped LDA bypasses EXEC2
      snap_acc = n_acc_en;
      eq = 1'b1;
      fetch_instr(16'h9000);
      tick(); eq = 1'b0; exp_ret++;
      fetch_instr(16'h0007);
      chk("lda_skip_e1", {acc_en_o, pc_cnt_en_o, extra_o}, 3'b010);
      tick(); exp_ret++;
      chk("lda_skip_done", {fetch_o, exec2_o, skip_o}, 3'b100);
      chk("lda_skip_acc", n_acc_en - snap_acc, 32'd0);

      // Jumps, store, immediate, shift, add
      eq = 1'b1;
      fetch_instr(16'h6123);
      chk("jeq_taken", {pc_sload_o, pc_cnt_en_o}, 2'b10);
      tick(); eq = 1'b0; exp_ret++;
      chk("jeq_noskip", skip_o, 1'b0);
      fetch_instr(16'h5044);
      chk("jmi_not", {pc_sload_o, pc_cnt_en_o}, 2'b01);
      tick(); exp_ret++;
      mem_ready = 1'b1; mem_rdata = 16'h1020; #1; tick();
      #1;
      chk("sta_write", {mux1_o, wren_o, pc_cnt_en_o}, 3'b111);
      tick(); exp_ret++;
      fetch_instr(16'h8077);
      chk("ldi", {acc_en_o, acc_load_o, mux3_o, pc_cnt_en_o}, 4'b1111);
      tick(); exp_ret++;
      mi = 1'b1;
      fetch_instr(16'hB000);
      chk("asr", {acc_en_o, mux3_all_o, acc_shiftin_o, pc_cnt_en_o}, 4'b1111);
      tick(); mi = 1'b0; exp_ret++;
      fetch_instr(16'h2003);
      tick();
      mem_ready = 1'b1; #1;
      chk("add_e2", {addsub_o, mux3_o, acc_en_o}, 3'b101);
      tick(); mem_ready = 1'b0; exp_ret++;
      chk("ret_mid", retired_o, exp_ret);

      // STP halts; RUN resumes with one PC increment and no extra retire
      run = 1'b1; #1;
      chk("run_ignored", fetch_o, 1'b1);
      run = 1'b0;
      fetch_instr(16'h7000);
      chk("stp_e1", {pc_cnt_en_o, pc_sload_o}, 2'b00);
      tick(); exp_ret++;
      snap_pc = n_pc_cnt;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("halt_quiet", {halted_o, mux1_o, mux3_o, mux3_all_o, extra_o, wren_o, pc_sload_o,
                            pc_cnt_en_o, acc_en_o, acc_load_o, acc_shiftin_o, addsub_o}, 12'h800);
         tick();
      end
      chk("halt_ret", retired_o, exp_ret);
      run = 1'b1; #1;
      chk("run_pc", pc_cnt_en_o, 1'b1);
      tick(); run = 1'b0;
      chk("run_fetch", {fetch_o, retired_o}, {1'b1, exp_ret[15:0]});
      chk("run_pulses", n_pc_cnt - snap_pc, 32'd1);

      // Reset in the middle of a store wait
      fetch_instr(16'h1010);
      chk("sta_pending", wren_o, 1'b1);
      tick();
      rst_n_i = 1'b0; #1;
      chk("rst_mid", {wren_o, fetch_o, retired_o}, {2'b01, 16'd0});
      chk("rst_mid_sat", retired2_o, 2'd0);
      tick(); rst_n_i = 1'b1; tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
